id_stage_pipe: RTL and testbench

- Parametrised next-generation decode stage: decodes one MIPS instruction per cycle, reads the register file, and resolves operands from NUM_FWD forwarding sources.
- Adds a registered ID/EX output with valid/ready handshake, a stall on not-yet-available forwarded data, and flush.
- Sits between the IF/ID register and the EX unit.

---
 rtl/id_stage_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS instruction decode stage with a registered ID/EX output.
//
// Decodes one instruction per cycle, drives the register file read ports,
// resolves each operand against NUM_FWD forwarding sources (index 0 is the
// youngest), and loads the result into an output register handed to EX.
//
// Optional feature: define ID_STALL_CNT_EN to add stall_cnt_o, a saturating
// count of cycles in which a valid instruction was offered but not accepted.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   pc_i, inst_i, inst_valid_i  incoming instruction from IF/ID
//   ready_o                     instruction accepted this cycle
//   re1_o/re2_o, raddr1_o/2_o   register file read request (combinational)
//   rdata1_i/rdata2_i           register file read data (same cycle)
//   fwd_we_i/_waddr_i/_wdata_i/_rdy_i   forwarding sources, slice k = source k
//   ex_ready_i                  EX takes the output register this cycle
//   flush_i                     discard held and incoming instruction
//   valid_o, pc_o, we_o, waddr_o, aluop_o, alusel_o, data1_o, data2_o,
//   inst_invalid_o              registered ID/EX output
//   stall_cnt_o                 (ID_STALL_CNT_EN only) stall cycle counter
//
// Handshake: upstream transfer happens on a clock edge where inst_valid_i and
// ready_o are both high; downstream transfer happens where valid_o and
// ex_ready_i are both high. Neither side may make its acceptance depend on
// seeing the other's valid/ready drop.
module id_stage_pipe #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          pc_i,
    input  logic [31:0]            inst_i,
    input  logic                   inst_valid_i,
    output logic                   ready_o,
    output logic                   re1_o,
    output logic                   re2_o,
    output logic [4:0]             raddr1_o,
    output logic [4:0]             raddr2_o,
    input  logic [DW-1:0]          rdata1_i,
    input  logic [DW-1:0]          rdata2_i,
    input  logic [NUM_FWD-1:0]     fwd_we_i,
    input  logic [5*NUM_FWD-1:0]   fwd_waddr_i,
    input  logic [DW*NUM_FWD-1:0]  fwd_wdata_i,
    input  logic [NUM_FWD-1:0]     fwd_rdy_i,
    input  logic                   ex_ready_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    output logic [AW-1:0]          pc_o,
    output logic                   we_o,
    output logic [4:0]             waddr_o,
    output logic [7:0]             aluop_o,
    output logic [2:0]             alusel_o,
    output logic [DW-1:0]          data1_o,
    output logic [DW-1:0]          data2_o,
    output logic                   inst_invalid_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    // ALU operation codes shared with EX
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_MOVZ = 8'h0A;
    localparam logic [7:0] OP_MOVN = 8'h0B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;

    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_MOVE  = 3'd3;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    // instruction fields
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign fn    = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    // decode results
    logic          re1, re2, we_dec, inv_dec, is_movn, is_movz;
    logic [4:0]    waddr_dec;
    logic [7:0]    aluop_dec;
    logic [2:0]    alusel_dec;
    logic [DW-1:0] imm_dec;

    always_comb begin
        re1        = 1'b0;
        re2        = 1'b0;
        we_dec     = 1'b0;
        inv_dec    = 1'b0;
        is_movn    = 1'b0;
        is_movz    = 1'b0;
        waddr_dec  = 5'd0;
        aluop_dec  = OP_NOP;
        alusel_dec = SEL_NOP;
        imm_dec    = '0;
        case (op)
            6'h00: begin
                // immediate shifts: rs must be zero, sa carried as operand 1
                if (rs == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
                    re2        = 1'b1;
                    we_dec     = 1'b1;
                    waddr_dec  = rd;
                    alusel_dec = SEL_SHIFT;
                    imm_dec    = DW'(sa);
                    aluop_dec  = (fn == 6'h00) ? OP_SLL : (fn == 6'h02) ? OP_SRL : OP_SRA;
                end else if (sa == 5'd0) begin
                    case (fn)
                        6'h24, 6'h25, 6'h26, 6'h27: begin
                            re1        = 1'b1;
                            re2        = 1'b1;
                            we_dec     = 1'b1;
                            waddr_dec  = rd;
                            alusel_dec = SEL_LOGIC;
                            aluop_dec  = (fn == 6'h24) ? OP_AND :
                                         (fn == 6'h25) ? OP_OR  :
                                         (fn == 6'h26) ? OP_XOR : OP_NOR;
                        end
                        6'h04, 6'h06, 6'h07: begin
                            re1        = 1'b1;
                            re2        = 1'b1;
                            we_dec     = 1'b1;
                            waddr_dec  = rd;
                            alusel_dec = SEL_SHIFT;
                            aluop_dec  = (fn == 6'h04) ? OP_SLL : (fn == 6'h06) ? OP_SRL : OP_SRA;
                        end
                        6'h0A, 6'h0B: begin
                            re1        = 1'b1;
                            re2        = 1'b1;
                            waddr_dec  = rd;
                            alusel_dec = SEL_MOVE;
                            is_movz    = (fn == 6'h0A);
                            is_movn    = (fn == 6'h0B);
                            aluop_dec  = (fn == 6'h0A) ? OP_MOVZ : OP_MOVN;
                        end
                        6'h10, 6'h12: begin
                            we_dec     = 1'b1;
                            waddr_dec  = rd;
                            alusel_dec = SEL_MOVE;
                            aluop_dec  = (fn == 6'h10) ? OP_MFHI : OP_MFLO;
                        end
                        6'h11, 6'h13: begin
                            re1        = 1'b1;
                            alusel_dec = SEL_MOVE;
                            aluop_dec  = (fn == 6'h11) ? OP_MTHI : OP_MTLO;
                        end
                        6'h0F: ; // sync: nop
                        default: inv_dec = 1'b1;
                    endcase
                end else begin
                    inv_dec = 1'b1;
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                re1        = 1'b1;
                we_dec     = 1'b1;
                waddr_dec  = rt;
                alusel_dec = SEL_LOGIC;
                imm_dec    = DW'(imm16);
                aluop_dec  = (op == 6'h0C) ? OP_AND : (op == 6'h0D) ? OP_OR : OP_XOR;
            end
            6'h0F: begin
                // lui computed as rs | (imm << 16)
                re1        = 1'b1;
                we_dec     = 1'b1;
                waddr_dec  = rt;
                alusel_dec = SEL_LOGIC;
                imm_dec    = DW'({imm16, 16'h0000});
                aluop_dec  = OP_OR;
            end
            6'h33: ; // pref: nop
            default: inv_dec = 1'b1;
        endcase
    end

    // Returns {hazard, value}. Sources are scanned oldest to youngest so the
    // youngest matching source is the one left standing.
    function automatic logic [DW:0] resolve(
        input logic [4:0]             addr,
        input logic [DW-1:0]          rf_data,
        input logic [NUM_FWD-1:0]     we,
        input logic [5*NUM_FWD-1:0]   wa,
        input logic [DW*NUM_FWD-1:0]  wd,
        input logic [NUM_FWD-1:0]     rdy
    );
        logic [DW:0] res;
        res = {1'b0, rf_data};
        if (addr == 5'd0) begin
            res = '0;
        end else begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (we[k] && wa[k*5 +: 5] == addr) begin
                    res = rdy[k] ? {1'b0, wd[k*DW +: DW]} : {1'b1, {DW{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    logic [DW:0]   r1, r2;
    logic [DW-1:0] opnd1, opnd2;
    logic          hazard, we_fin, advance, load;

    always_comb begin
        r1     = resolve(rs, rdata1_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_rdy_i);
        r2     = resolve(rt, rdata2_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_rdy_i);
        opnd1  = re1 ? r1[DW-1:0] : imm_dec;
        opnd2  = re2 ? r2[DW-1:0] : imm_dec;
        hazard = (re1 & r1[DW]) | (re2 & r2[DW]);
        we_fin = is_movn ? (opnd2 != '0) : is_movz ? (opnd2 == '0) : we_dec;
    end

    assign re1_o    = rst & re1;
    assign re2_o    = rst & re2;
    assign raddr1_o = rst ? rs : 5'd0;
    assign raddr2_o = rst ? rt : 5'd0;

    // FSM: EMPTY / FULL output register
    state_t state_q, state_d;

    assign advance = (state_q == S_EMPTY) | ex_ready_i;
    assign ready_o = rst & advance & ~hazard & ~flush_i;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else if (advance) begin
            if (inst_valid_i && !hazard) begin
                state_d = S_FULL;
                load    = 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_EMPTY;
        else      state_q <= state_d;
    end

    assign valid_o = (state_q == S_FULL);

    // output register; payload only changes on load so a held entry is stable
    logic [AW-1:0] pc_q;
    logic          we_q, inv_q;
    logic [4:0]    waddr_q;
    logic [7:0]    aluop_q;
    logic [2:0]    alusel_q;
    logic [DW-1:0] data1_q, data2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= '0;
            we_q     <= 1'b0;
            inv_q    <= 1'b0;
            waddr_q  <= 5'd0;
            aluop_q  <= 8'd0;
            alusel_q <= 3'd0;
            data1_q  <= '0;
            data2_q  <= '0;
        end else if (load) begin
            pc_q     <= pc_i;
            we_q     <= we_fin;
            inv_q    <= inv_dec;
            waddr_q  <= waddr_dec;
            aluop_q  <= aluop_dec;
            alusel_q <= alusel_dec;
            data1_q  <= opnd1;
            data2_q  <= opnd2;
        end
    end

    assign pc_o           = pc_q;
    assign we_o           = we_q;
    assign inst_invalid_o = inv_q;
    assign waddr_o        = waddr_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign data1_o        = data1_q;
    assign data2_o        = data2_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
        end else if (inst_valid_i && !ready_o && !flush_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i, inst_i;
    logic        inst_valid_i, ready_o, re1_o, re2_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic [1:0]  fwd_we_i, fwd_rdy_i;
    logic [9:0]  fwd_waddr_i;
    logic [63:0] fwd_wdata_i;
    logic        ex_ready_i, flush_i, valid_o, we_o, inst_invalid_o;
    logic [31:0] pc_o, data1_o, data2_o;
    logic [4:0]  waddr_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    id_stage_pipe #(.DW(32), .AW(32), .NUM_FWD(2)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .ready_o(ready_o), .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i),
        .fwd_wdata_i(fwd_wdata_i), .fwd_rdy_i(fwd_rdy_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
        .valid_o(valid_o), .pc_o(pc_o), .we_o(we_o), .waddr_o(waddr_o), .aluop_o(aluop_o),
        .alusel_o(alusel_o), .data1_o(data1_o), .data2_o(data2_o), .inst_invalid_o(inst_invalid_o)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected decode record
    typedef struct packed {
        logic        hz;
        logic        re1;
        logic        re2;
        logic        we;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        inv;
    } exp_t;

    typedef struct {
        logic [31:0] inst, rd1, rd2;
        logic [1:0]  fwe;
        logic [9:0]  fwa;
        logic [63:0] fwd;
        logic [1:0]  frdy;
        logic        we;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] d1, d2;
        logic        inv;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: register value seen by an operand, {hazard, value}
    function automatic logic [32:0] ref_read(input logic [4:0] a, input logic [31:0] rf,
                                             input logic [1:0] fwe, input logic [9:0] fwa,
                                             input logic [63:0] fwd, input logic [1:0] frdy);
        if (a == 5'd0) return 33'd0;
        for (int k = 0; k < 2; k++)
            if (fwe[k] && fwa[k*5 +: 5] == a)
                return frdy[k] ? {1'b0, fwd[k*32 +: 32]} : {1'b1, 32'd0};
        return {1'b0, rf};
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [1:0] fwe, input logic [9:0] fwa,
                                   input logic [63:0] fwd, input logic [1:0] frdy);
        exp_t e;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, sa;
        logic [31:0] imm;
        logic [32:0] r;
        logic ok, mz, mn;
        e = '0; imm = 32'd0; ok = 1'b1; mz = 1'b0; mn = 1'b0;
        op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
        rd = inst[15:11]; sa = inst[10:6];  fn = inst[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03} && rs == 5'd0) begin
                e.re2 = 1; imm = {27'd0, sa}; e.we = 1; e.waddr = rd; e.alusel = 3'd2;
                e.aluop = (fn == 6'h00) ? 8'h7C : {6'd0, fn[1:0]};
            end else if (sa != 5'd0) ok = 0;
            else if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
                e.re1 = 1; e.re2 = 1; e.we = 1; e.waddr = rd; e.alusel = 3'd1; e.aluop = {2'b00, fn};
            end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
                e.re1 = 1; e.re2 = 1; e.we = 1; e.waddr = rd; e.alusel = 3'd2;
                e.aluop = (fn == 6'h04) ? 8'h7C : {6'd0, fn[1:0]};
            end else if (fn inside {6'h0A, 6'h0B}) begin
                e.re1 = 1; e.re2 = 1; e.waddr = rd; e.alusel = 3'd3; e.aluop = {2'b00, fn};
                mz = (fn == 6'h0A); mn = (fn == 6'h0B);
            end else if (fn inside {6'h10, 6'h12}) begin
                e.we = 1; e.waddr = rd; e.alusel = 3'd3; e.aluop = {2'b00, fn};
            end else if (fn inside {6'h11, 6'h13}) begin
                e.re1 = 1; e.alusel = 3'd3; e.aluop = {2'b00, fn};
            end else if (fn != 6'h0F) ok = 0;
        end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            e.re1 = 1; e.we = 1; e.waddr = rt; e.alusel = 3'd1; imm = {16'd0, inst[15:0]};
            e.aluop = 8'h24 + {6'd0, op[1:0]};
        end else if (op == 6'h0F) begin
            e.re1 = 1; e.we = 1; e.waddr = rt; e.alusel = 3'd1; e.aluop = 8'h25; imm = {inst[15:0], 16'd0};
        end else if (op != 6'h33) ok = 0;
        e.inv = ~ok;
        if (e.re1) begin r = ref_read(rs, rd1, fwe, fwa, fwd, frdy); e.hz |= r[32]; e.d1 = r[31:0]; end
        else e.d1 = imm;
        if (e.re2) begin r = ref_read(rt, rd2, fwe, fwa, fwd, frdy); e.hz |= r[32]; e.d2 = r[31:0]; end
        else e.d2 = imm;
        if (mz) e.we = (e.d2 == 32'd0);
        if (mn) e.we = (e.d2 != 32'd0);
        return e;
    endfunction

    // driver tasks
    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [1:0] fwe, input logic [9:0] fwa,
                         input logic [63:0] fwd, input logic [1:0] frdy, input logic vld, input logic exr);
        @(negedge clk);
        inst_i = inst; pc_i = pc; rdata1_i = rd1; rdata2_i = rd2;
        fwd_we_i = fwe; fwd_waddr_i = fwa; fwd_wdata_i = fwd; fwd_rdy_i = frdy;
        inst_valid_i = vld; ex_ready_i = exr;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                           input logic [7:0] aop, input logic [2:0] asel, input logic [31:0] d1,
                           input logic [31:0] d2, input logic inv);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".we"}, we_o, we);
        chk({tag, ".waddr"}, waddr_o, wa);
        chk({tag, ".aluop"}, aluop_o, aop);
        chk({tag, ".alusel"}, alusel_o, asel);
        chk({tag, ".data1"}, data1_o, d1);
        chk({tag, ".data2"}, data2_o, d2);
        chk({tag, ".inv"}, inst_invalid_o, inv);
    endtask

    vec_t vecs[13];
    logic [31:0] exp_q[$];

    initial begin
        exp_t e;
        logic [31:0] inst, pc, rd1, rd2;
        logic [1:0]  fwe, frdy;
        logic [9:0]  fwa;
        logic [63:0] fwd;
        logic [4:0]  a, b, c;
        int kind;

        vecs[0]  = '{32'h34011234, 0, 0, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd1, 8'h25, 3'd1, 32'h0, 32'h00001234, 0};
        vecs[1]  = '{32'h3C01ABCD, 0, 0, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd1, 8'h25, 3'd1, 32'h0, 32'hABCD0000, 0};
        vecs[2]  = '{32'h00221824, 32'h11, 32'h22, 2'b11, {5'd1, 5'd1}, {32'h1, 32'hFFFF0000}, 2'b11,
                     1, 5'd3, 8'h24, 3'd1, 32'hFFFF0000, 32'h22, 0};
        vecs[3]  = '{32'h00021824, 32'h99, 32'h22, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h5}, 2'b01,
                     1, 5'd3, 8'h24, 3'd1, 32'h0, 32'h22, 0};
        vecs[4]  = '{32'h0022180A, 32'h11, 32'h0, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd3, 8'h0A, 3'd3, 32'h11, 32'h0, 0};
        vecs[5]  = '{32'h0022180A, 32'h11, 32'h7, 2'b00, 10'd0, 64'd0, 2'b00, 0, 5'd3, 8'h0A, 3'd3, 32'h11, 32'h7, 0};
        vecs[6]  = '{32'hFC000000, 32'h11, 32'h7, 2'b00, 10'd0, 64'd0, 2'b00, 0, 5'd0, 8'h00, 3'd0, 32'h0, 32'h0, 1};
        vecs[7]  = '{32'h00011100, 32'h33, 32'hF0, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd2, 8'h7C, 3'd2, 32'h4, 32'hF0, 0};
        vecs[8]  = '{32'h00002810, 32'h33, 32'h44, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd5, 8'h10, 3'd3, 32'h0, 32'h0, 0};
        vecs[9]  = '{32'h0000000F, 32'h33, 32'h44, 2'b00, 10'd0, 64'd0, 2'b00, 0, 5'd0, 8'h00, 3'd0, 32'h0, 32'h0, 0};
        vecs[10] = '{32'h3864FFFF, 32'h12345678, 0, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd4, 8'h26, 3'd1,
                     32'h12345678, 32'h0000FFFF, 0};
        vecs[11] = '{32'h01073007, 32'hA5, 32'h5A, 2'b00, 10'd0, 64'd0, 2'b00, 1, 5'd6, 8'h03, 3'd2, 32'hA5, 32'h5A, 0};
        vecs[12] = '{32'h00221824, 32'h11, 32'h22, 2'b11, {5'd1, 5'd2}, {32'hBB, 32'hAA}, 2'b11,
                     1, 5'd3, 8'h24, 3'd1, 32'hBB, 32'hAA, 0};

        // reset with a register-reading instruction on the inputs
        rst = 1'b0; flush_i = 1'b0;
        inst_i = 32'h00221824; pc_i = 32'h40; inst_valid_i = 1'b1; ex_ready_i = 1'b1;
        rdata1_i = 0; rdata2_i = 0; fwd_we_i = 0; fwd_waddr_i = 0; fwd_wdata_i = 0; fwd_rdy_i = 0;
        repeat (3) edge_wait();
        chk("rst.ready", ready_o, 0);
        chk("rst.raddr1", raddr1_o, 0);
        chk("rst.re1", re1_o, 0);
        chk("rst.valid", valid_o, 0);
        chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; inst_valid_i = 1'b0;

        // table-driven vectors
        foreach (vecs[i]) begin
            pc = 32'h1000 + 32'(i) * 4;
            drive(vecs[i].inst, pc, vecs[i].rd1, vecs[i].rd2, vecs[i].fwe, vecs[i].fwa,
                  vecs[i].fwd, vecs[i].frdy, 1, 1);
            chk($sformatf("vec%0d.ready", i), ready_o, 1);
            edge_wait();
            chk($sformatf("vec%0d.valid", i), valid_o, 1);
            chk_out($sformatf("vec%0d", i), pc, vecs[i].we, vecs[i].waddr, vecs[i].aluop,
                    vecs[i].alusel, vecs[i].d1, vecs[i].d2, vecs[i].inv);
        end

        // randomized stimulus against the reference model
        for (int n = 0; n < 300; n++) begin
            a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 31));
            kind = $urandom_range(0, 22);
            case (kind)
                0, 1, 2, 3:  inst = {6'h00, a, b, c, 5'd0, 6'h24 + 6'(kind)};
                4:           inst = {6'h00, a, b, c, 5'd0, 6'h04};
                5:           inst = {6'h00, a, b, c, 5'd0, 6'h06};
                6:           inst = {6'h00, a, b, c, 5'd0, 6'h07};
                7:           inst = {6'h00, 5'd0, b, c, 5'($urandom), 6'h00};
                8:           inst = {6'h00, 5'd0, b, c, 5'($urandom), 6'h02};
                9:           inst = {6'h00, 5'd0, b, c, 5'($urandom), 6'h03};
                10:          inst = {6'h00, a, b, c, 5'd0, 6'h0B};
                11:          inst = {6'h00, a, b, c, 5'd0, 6'h0A};
                12:          inst = {6'h00, 10'd0, c, 5'd0, 6'h10};
                13:          inst = {6'h00, 10'd0, c, 5'd0, 6'h12};
                14:          inst = {6'h00, a, 15'd0, 6'h11};
                15:          inst = {6'h00, a, 15'd0, 6'h13};
                16:          inst = {6'h0D, a, b, 16'($urandom)};
                17:          inst = {6'h0C, a, b, 16'($urandom)};
                18:          inst = {6'h0E, a, b, 16'($urandom)};
                19:          inst = {6'h0F, 5'd0, b, 16'($urandom)};
                20:          inst = 32'h0000000F;
                21:          inst = {6'h33, 26'($urandom)};
                default:     inst = $urandom;
            endcase
            rd1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rd2  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            fwe  = 2'($urandom);
            fwa  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd  = {32'($urandom), 32'($urandom)};
            frdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            pc   = $urandom;
            e = model(inst, rd1, rd2, fwe, fwa, fwd, frdy);
            drive(inst, pc, rd1, rd2, fwe, fwa, fwd, frdy, 1, 1);
            chk("rnd.ready", ready_o, !e.hz);
            chk("rnd.re1", re1_o, e.re1);
            chk("rnd.re2", re2_o, e.re2);
            chk("rnd.raddr1", raddr1_o, inst[25:21]);
            chk("rnd.raddr2", raddr2_o, inst[20:16]);
            if (!e.hz) begin
                exp_q.push_back(e.d1);
                exp_q.push_back(e.d2);
            end
            edge_wait();
            chk("rnd.valid", valid_o, !e.hz);
            if (!e.hz) begin
                chk_out("rnd", pc, e.we, e.waddr, e.aluop, e.alusel, e.d1, e.d2, e.inv);
                chk("rnd.q_d1", data1_o, exp_q.pop_front());
                chk("rnd.q_d2", data2_o, exp_q.pop_front());
            end
        end

        // hold: FULL with ex_ready low for 3 cycles, then back-to-back transfer
        drive(32'h34011234, 32'h2000, 0, 0, 0, 0, 0, 0, 1, 1);
        edge_wait();
        for (int i = 0; i < 3; i++) begin
            drive(32'h3864FFFF, 32'h2004, 32'h12345678, 0, 0, 0, 0, 0, 1, 0);
            chk("hold.ready", ready_o, 0);
            edge_wait();
            chk("hold.valid", valid_o, 1);
            chk_out("hold", 32'h2000, 1, 5'd1, 8'h25, 3'd1, 32'h0, 32'h1234, 0);
        end
        drive(32'h3864FFFF, 32'h2004, 32'h12345678, 0, 0, 0, 0, 0, 1, 1);
        chk("b2b.ready", ready_o, 1);
        edge_wait();
        chk("b2b.valid", valid_o, 1);
        chk_out("b2b", 32'h2004, 1, 5'd4, 8'h26, 3'd1, 32'h12345678, 32'h0000FFFF, 0);

        // flush while held and stalling on a hazard
        drive(32'h00221824, 32'h2008, 0, 0, 2'b01, {5'd0, 5'd2}, 0, 2'b00, 1, 0);
        @(negedge clk); flush_i = 1'b1; #1;
        chk("flush1.ready", ready_o, 0);
        edge_wait();
        chk("flush1.valid", valid_o, 0);
        // flush discards an otherwise acceptable instruction
        drive(32'h34011234, 32'h200C, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("flush2.ready", ready_o, 0);
        edge_wait();
        chk("flush2.valid", valid_o, 0);
        @(negedge clk); flush_i = 1'b0;

        // reset in the middle of a hold
        drive(32'h34011234, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 1);
        edge_wait();
        chk("prerst.valid", valid_o, 1);
        drive(32'h00221824, 32'h3004, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst.ready", ready_o, 0);
        chk("midrst.raddr2", raddr2_o, 0);
        edge_wait();
        chk("midrst.valid", valid_o, 0);
        chk_out("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ID_STALL_CNT_EN
        chk("midrst.stall_cnt", stall_cnt_o, 0);
`endif
        @(negedge clk); rst = 1'b1; inst_valid_i = 1'b0; ex_ready_i = 1'b1;

        // 2-cycle hazard stall on rt, then forwarded data becomes final
        for (int i = 0; i < 2; i++) begin
            drive(32'h00221824, 32'h4000, 32'h11, 32'h22, 2'b01, {5'd0, 5'd2}, 64'd0, 2'b00, 1, 1);
            chk("stall.ready", ready_o, 0);
            edge_wait();
            chk("stall.valid", valid_o, 0);
        end
        drive(32'h00221824, 32'h4000, 32'h11, 32'h22, 2'b01, {5'd0, 5'd2}, 64'h55, 2'b01, 1, 1);
        chk("stall_end.ready", ready_o, 1);
        edge_wait();
        chk("stall_end.valid", valid_o, 1);
        chk_out("stall_end", 32'h4000, 1, 5'd3, 8'h24, 3'd1, 32'h11, 32'h55, 0);
`ifdef ID_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, 2);
`endif
        @(negedge clk); inst_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
